// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single register-file write port between the
// pipeline WB stage and MDU results. MDU results wait in a small FIFO and
// drain into cycles WB leaves idle. A starvation guard holds WB for one cycle
// when the FIFO head has waited STARVE_MAX cycles. A scoreboard over the
// FIFO raises raw_stall when an ID source register is still pending.
// Optional feature macro: RF_ARB_BYPASS_EN. It writes an MDU result straight
// to the port when the FIFO is empty and WB is idle.
// Ports:
//   clk, clrn               clock, synchronous active-high reset
//   wb_wreg/wb_rn/wb_d      WB write request
//   md_valid/md_rn/md_d     MDU result, accepted when md_valid & md_ready
//   md_ready                FIFO has room
//   id_rs/id_rt, raw_stall  ID sources and pending-destination stall
//   wb_hold                 WB must hold and re-present its write
//   rf_we/rf_rn/rf_d        register-file write port (combinational)
module rf_wport_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wb_wreg,
  input  logic [4:0]  wb_rn,
  input  logic [31:0] wb_d,
  input  logic        md_valid,
  input  logic [4:0]  md_rn,
  input  logic [31:0] md_d,
  output logic        md_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        raw_stall,
  output logic        wb_hold,
  output logic        rf_we,
  output logic [4:0]  rf_rn,
  output logic [31:0] rf_d
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       rn_q [DEPTH];
  logic [4:0]       rn_d [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [31:0]      dat_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;

  logic empty_c, head_v_c, wb_active_c, bypass_c;
  logic head_grant_c, wb_grant_c, pop_c, push_c, raw_hit_c;

  assign empty_c     = (count_q == '0);
  assign head_v_c    = ~empty_c & valid_q[rd_ptr_q];
  assign wb_active_c = wb_wreg & (wb_rn != 5'd0);

`ifdef RF_ARB_BYPASS_EN
  // Empty FIFO and idle WB: the MDU result takes the port directly.
  assign bypass_c = ~clrn & empty_c & ~wb_active_c & md_valid & (md_rn != 5'd0);
`else
  assign bypass_c = 1'b0;
`endif

  assign md_ready = ~clrn & (count_q < CNT_W'(DEPTH));
  // A hold always pops the head and clears the counter, so it cannot repeat
  // on the following cycle.
  assign wb_hold  = ~clrn & (starve_q == STV_W'(STARVE_MAX)) & head_v_c;

  // Write-port grant by priority.
  always_comb begin
    rf_we        = 1'b0;
    rf_rn        = 5'd0;
    rf_d         = 32'd0;
    head_grant_c = 1'b0;
    wb_grant_c   = 1'b0;
    if (!clrn) begin
      if (wb_hold || (!wb_active_c && head_v_c)) begin
        head_grant_c = 1'b1;
        rf_we        = 1'b1;
        rf_rn        = rn_q[rd_ptr_q];
        rf_d         = dat_q[rd_ptr_q];
      end else if (wb_active_c) begin
        wb_grant_c = 1'b1;
        rf_we      = 1'b1;
        rf_rn      = wb_rn;
        rf_d       = wb_d;
      end else if (bypass_c) begin
        rf_we = 1'b1;
        rf_rn = md_rn;
        rf_d  = md_d;
      end
    end
  end

  // Scoreboard: any live queued destination matching an ID source.
  always_comb begin
    raw_hit_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rn_q[i] != 5'd0) && ((rn_q[i] == id_rs) || (rn_q[i] == id_rt)))
        raw_hit_c = 1'b1;
    end
  end
  assign raw_stall = ~clrn & raw_hit_c;

  // Killed heads leave without using the port; live heads leave when granted.
  assign pop_c  = ~empty_c & (~valid_q[rd_ptr_q] | head_grant_c);
  // rn 0 and WAW-shadowed transfers are accepted but never stored.
  assign push_c = md_valid & md_ready & (md_rn != 5'd0) & ~bypass_c
                & ~(wb_grant_c & (md_rn == wb_rn));

  // FIFO, kill and starvation next state.
  always_comb begin
    valid_d  = valid_q;
    rn_d     = rn_q;
    dat_d    = dat_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (wb_grant_c) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rn_q[i] == wb_rn) valid_d[i] = 1'b0;
      end
    end
    if (pop_c) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push_c) begin
      valid_d[wr_ptr_q] = 1'b1;
      rn_d[wr_ptr_q]    = md_rn;
      dat_d[wr_ptr_q]   = md_d;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    if (pop_c || empty_c)
      starve_d = '0;
    else if (head_v_c && (starve_q != STV_W'(STARVE_MAX)))
      starve_d = starve_q + STV_W'(1);
  end

  // State register; payload fields need no reset since valid gates them.
  always_ff @(posedge clk) begin
    if (clrn) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      rn_q     <= rn_d;
      dat_q    <= dat_d;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SMAX  = 8;

  logic        clk = 1'b0;
  logic        clrn, wb_wreg, md_valid, md_ready, raw_stall, wb_hold, rf_we;
  logic [4:0]  wb_rn, md_rn, id_rs, id_rt, rf_rn;
  logic [31:0] wb_d, md_d, rf_d;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .clrn(clrn),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_d(wb_d),
    .md_valid(md_valid), .md_rn(md_rn), .md_d(md_d), .md_ready(md_ready),
    .id_rs(id_rs), .id_rt(id_rt), .raw_stall(raw_stall), .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_rn(rf_rn), .rf_d(rf_d)
  );

  // Reference model: a queue of pending MDU results plus a wait counter.
  typedef struct {
    bit        v;
    bit [4:0]  rn;
    bit [31:0] d;
  } ent_t;

  ent_t q[$];
  int   starve;
  int   checks;
  int   failures;
  int   holds_seen;
  bit   prev_hold;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance model.
  task automatic step(input bit rst, input bit wv, input logic [4:0] wrn, input logic [31:0] wd,
                      input bit mv, input logic [4:0] mrn, input logic [31:0] mdd,
                      input logic [4:0] rs, input logic [4:0] rt);
    bit hv, hold, wba, byp, ready, raw, head_used, wb_g, pop, push, e_we;
    bit [4:0]  e_rn;
    bit [31:0] e_d;
    @(negedge clk);
    clrn = rst; wb_wreg = wv; wb_rn = wrn; wb_d = wd;
    md_valid = mv; md_rn = mrn; md_d = mdd; id_rs = rs; id_rt = rt;
    #1;
    if (rst) begin
      check_val("rst_we", rf_we, 0);
      check_val("rst_ready", md_ready, 0);
      check_val("rst_hold", wb_hold, 0);
      check_val("rst_raw", raw_stall, 0);
      q.delete();
      starve = 0;
      prev_hold = 0;
      return;
    end

    hv    = (q.size() > 0) && q[0].v;
    hold  = (starve == SMAX) && hv;
    wba   = wv && (wrn != 0);
    ready = q.size() < DEPTH;
`ifdef RF_ARB_BYPASS_EN
    byp   = (q.size() == 0) && !wba && mv && (mrn != 0);
`else
    byp   = 0;
`endif
    raw = 0;
    foreach (q[i]) if (q[i].v && q[i].rn != 0 && (q[i].rn == rs || q[i].rn == rt)) raw = 1;

    head_used = 0; e_we = 0; e_rn = 0; e_d = 0;
    if (hold)      begin e_we = 1; e_rn = q[0].rn; e_d = q[0].d; head_used = 1; end
    else if (wba)  begin e_we = 1; e_rn = wrn; e_d = wd; end
    else if (hv)   begin e_we = 1; e_rn = q[0].rn; e_d = q[0].d; head_used = 1; end
    else if (byp)  begin e_we = 1; e_rn = mrn; e_d = mdd; end

    check_val("rf_we", rf_we, e_we);
    if (e_we) begin
      check_val("rf_rn", rf_rn, e_rn);
      check_val("rf_d", rf_d, e_d);
    end
    check_val("md_ready", md_ready, ready);
    check_val("wb_hold", wb_hold, hold);
    check_val("raw_stall", raw_stall, raw);
    if (prev_hold) check_val("hold_consec", wb_hold, 0);
    prev_hold = wb_hold;
    if (hold) holds_seen++;

    // Advance the model as of the coming clock edge.
    pop  = (q.size() > 0) && (!q[0].v || head_used);
    wb_g = !hold && wba;
    if (wb_g) foreach (q[i]) if (q[i].rn == wrn) q[i].v = 0;
    push = mv && ready && (mrn != 0) && !(wb_g && mrn == wrn) && !byp;
    if (pop || q.size() == 0) starve = 0;
    else if (hv && starve < SMAX) starve++;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{v: 1'b1, rn: mrn, d: mdd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0; failures = 0; holds_seen = 0; prev_hold = 0; starve = 0;
    clrn = 1; wb_wreg = 0; wb_rn = 0; wb_d = 0; md_valid = 0; md_rn = 0; md_d = 0;
    id_rs = 0; id_rt = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single MDU write with WB idle.
    step(0, 0, 0, 0, 1, 5, 32'h1234, 5, 0);
    idle(2);

    // Fill while WB hammers r3 until the starvation hold fires.
    for (int i = 0; i < 16; i++)
      step(0, 1, 3, 32'h3000 + i, (i < 6), 5'(10 + i), 32'hA0 + i, 12, 11);
    idle(6);

    // WAW kill: queued r7 is superseded by WB r7.
    step(0, 1, 3, 32'h33, 1, 7, 32'hAAAA, 7, 0);
    step(0, 1, 7, 32'hBBBB, 0, 0, 0, 7, 0);
    idle(3);

    // Same-cycle MDU and WB to r9.
    step(0, 1, 9, 32'h9999, 1, 9, 32'h1111, 9, 9);
    idle(2);

    // rn 0 transfer, then WB to r0 with a queued head.
    step(0, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0);
    step(0, 1, 3, 32'h1, 1, 4, 32'h44, 4, 0);
    step(0, 1, 0, 32'h2, 0, 0, 0, 4, 0);
    idle(2);

    // Reset mid-queue.
    for (int i = 0; i < 3; i++) step(0, 1, 3, 32'h5, 1, 5'(20 + i), 32'h200 + i, 21, 0);
    step(1, 0, 0, 0, 0, 0, 0, 21, 0);
    step(0, 0, 0, 0, 0, 0, 0, 21, 22);

    // Randomized traffic alternating light and heavy WB load.
    for (int i = 0; i < 3000; i++) begin
      bit heavy;
      heavy = ((i / 250) % 2) == 1;
      step(($urandom_range(0, 199) == 0),
           heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    check_val("holds_seen", (holds_seen > 0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
